// File: rtl/ao_ini_pkg.sv
// AO init sequencer shared definitions: channel count, timeout,
// config base address, widths and one-hot state encodings.
package ao_ini_pkg;

  localparam int         AO_CH_NUM    = 8;
  localparam int         AO_TO_CYCLES = 1000;
  localparam logic [7:0] AO_CFG_BASE  = 8'h00;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_REQ  = 6'b000010,
    ST_CHK  = 6'b000100,
    ST_WR   = 6'b001000,
    ST_DONE = 6'b010000,
    ST_FAIL = 6'b100000
  } ini_state_t;

  // Checksum accumulate, carries discarded.
  function automatic logic [DATA_W-1:0] csum_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/ao_ini_wdog.sv
// Config-ack watchdog. Ports: clk, rst, clr (restart), en (count),
// expire (asserted on the TO_CYCLES-th cycle since the last clear).
module ao_ini_wdog
  import ao_ini_pkg::*;
#(
  parameter int TO_CYCLES = AO_TO_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // The clearing cycle itself counts as elapsed, so cnt_q equals the
  // number of cycles since the last ack/start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= CW'(1);
    end else if (en && cnt_q != CW'(TO_CYCLES)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire = en && !clr && (cnt_q >= CW'(TO_CYCLES - 1));

endmodule

// File: rtl/ao_ini_seq.sv
// AO channel init sequencer: reads CH_NUM defaults + checksum, verifies,
// then writes all channels. Ports: clk/rst, start/done/fail/busy,
// cfg req/addr/ack/data read port, ch_wr/sel/data write strobe.
module ao_ini_seq
  import ao_ini_pkg::*;
#(
  parameter int         CH_NUM    = AO_CH_NUM,
  parameter int         TO_CYCLES = AO_TO_CYCLES,
  parameter logic [7:0] CFG_BASE  = AO_CFG_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ini_start,
  output logic              o_ini_done,
  output logic              o_ini_fail,
  output logic              o_busy,
  output logic              o_cfg_req,
  output logic [ADDR_W-1:0] om_cfg_addr,
  input  logic              i_cfg_ack,
  input  logic [DATA_W-1:0] im_cfg_data,
  output logic              o_ch_wr,
  output logic [SEL_W-1:0]  om_ch_sel,
  output logic [DATA_W-1:0] om_ch_data
);

  localparam int IDX_W = $clog2(CH_NUM + 1);

  ini_state_t        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] chk_q;
  logic [DATA_W-1:0] buf_q [2**SEL_W];

  logic wd_clr;
  logic wd_en;
  logic wd_exp;

  assign wd_en  = (state_q == ST_REQ);
  assign wd_clr = ((state_q == ST_IDLE) && i_ini_start)
               || ((state_q == ST_REQ) && i_cfg_ack);

  ao_ini_wdog #(
    .TO_CYCLES (TO_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_exp)
  );

  // Channel defaults; only read after the checksum passes.
  always_ff @(posedge clk) begin
    if (state_q == ST_REQ && i_cfg_ack
        && idx_q < IDX_W'(CH_NUM)) begin
      buf_q[idx_q[SEL_W-1:0]] <= im_cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      csum_q      <= '0;
      chk_q       <= '0;
      o_ini_done  <= 1'b0;
      o_ini_fail  <= 1'b0;
      o_busy      <= 1'b0;
      o_cfg_req   <= 1'b0;
      om_cfg_addr <= CFG_BASE;
      o_ch_wr     <= 1'b0;
      om_ch_sel   <= '0;
      om_ch_data  <= '0;
    end else begin
      o_ini_done <= 1'b0;
      o_ini_fail <= 1'b0;
      o_ch_wr    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_ini_start) begin
            state_q     <= ST_REQ;
            o_cfg_req   <= 1'b1;
            o_busy      <= 1'b1;
            om_cfg_addr <= CFG_BASE;
            idx_q       <= '0;
            csum_q      <= '0;
          end
        end
        ST_REQ: begin
          if (i_cfg_ack) begin
            om_cfg_addr <= om_cfg_addr + 8'd1;
            idx_q       <= idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(CH_NUM)) begin
              chk_q     <= im_cfg_data;
              o_cfg_req <= 1'b0;
              state_q   <= ST_CHK;
            end else begin
              csum_q <= csum_add(csum_q, im_cfg_data);
            end
          end else if (wd_exp) begin
            o_cfg_req  <= 1'b0;
            o_ini_fail <= 1'b1;
            state_q    <= ST_FAIL;
          end
        end
        ST_CHK: begin
          if (csum_q == chk_q) begin
            o_ch_wr    <= 1'b1;
            om_ch_sel  <= '0;
            om_ch_data <= buf_q[0];
            state_q    <= ST_WR;
          end else begin
            o_ini_fail <= 1'b1;
            state_q    <= ST_FAIL;
          end
        end
        ST_WR: begin
          if (om_ch_sel == SEL_W'(CH_NUM - 1)) begin
            o_ini_done <= 1'b1;
            om_ch_data <= '0;
            state_q    <= ST_DONE;
          end else begin
            o_ch_wr    <= 1'b1;
            om_ch_sel  <= om_ch_sel + SEL_W'(1);
            om_ch_data <= buf_q[om_ch_sel + SEL_W'(1)];
          end
        end
        ST_DONE, ST_FAIL: begin
          o_busy  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          o_busy    <= 1'b0;
          o_cfg_req <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ao_ini_seq.sv
// Scoreboard bench for ao_ini_seq: expected writes and done/fail
// events are queued per scenario and matched as the DUT emits them.
module tb_ao_ini_seq;
  import ao_ini_pkg::*;

  localparam int         CH   = AO_CH_NUM;
  localparam int         TO   = AO_TO_CYCLES;
  localparam logic [7:0] BASE = AO_CFG_BASE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ini_start = 1'b0;
  logic        o_ini_done;
  logic        o_ini_fail;
  logic        o_busy;
  logic        o_cfg_req;
  logic [7:0]  om_cfg_addr;
  logic        i_cfg_ack = 1'b0;
  logic [15:0] im_cfg_data;
  logic        o_ch_wr;
  logic [2:0]  om_ch_sel;
  logic [15:0] om_ch_data;

  ao_ini_seq #(
    .CH_NUM    (CH),
    .TO_CYCLES (TO),
    .CFG_BASE  (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ini_start (i_ini_start),
    .o_ini_done  (o_ini_done),
    .o_ini_fail  (o_ini_fail),
    .o_busy      (o_busy),
    .o_cfg_req   (o_cfg_req),
    .om_cfg_addr (om_cfg_addr),
    .i_cfg_ack   (i_cfg_ack),
    .im_cfg_data (im_cfg_data),
    .o_ch_wr     (o_ch_wr),
    .om_ch_sel   (om_ch_sel),
    .om_ch_data  (om_ch_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [CH+1];
  int          ridx;
  always_comb begin
    ridx = int'(om_cfg_addr) - int'(BASE);
    im_cfg_data = 16'hBAD0;
    if (ridx >= 0 && ridx <= CH) im_cfg_data = mem[ridx];
  end

  typedef struct {
    int          c;
    logic [2:0]  sel;
    logic [15:0] data;
  } wr_t;
  typedef struct {
    int c;
    bit fail;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];
  wr_t we;
  ev_t ee;
  int  vecs = 0;
  int  errs = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_ch_wr) begin
        vecs++;
        if (wq.size() == 0) begin
          errs++;
          $display("FAIL wr_unexpected: cyc %0d sel %0d data %h, none expected",
                   cyc, om_ch_sel, om_ch_data);
        end else begin
          we = wq.pop_front();
          if (cyc !== we.c || om_ch_sel !== we.sel || om_ch_data !== we.data) begin
            errs++;
            $display("FAIL wr: got cyc %0d sel %0d data %h, want cyc %0d sel %0d data %h",
                     cyc, om_ch_sel, om_ch_data, we.c, we.sel, we.data);
          end
        end
      end
      if (o_ini_done || o_ini_fail) begin
        vecs++;
        if (eq.size() == 0) begin
          errs++;
          $display("FAIL ev_unexpected: cyc %0d done %b fail %b", cyc, o_ini_done, o_ini_fail);
        end else begin
          ee = eq.pop_front();
          if (cyc !== ee.c || o_ini_done !== !ee.fail || o_ini_fail !== ee.fail) begin
            errs++;
            $display("FAIL ev: got cyc %0d done %b fail %b, want cyc %0d done %b fail %b",
                     cyc, o_ini_done, o_ini_fail, ee.c, !ee.fail, ee.fail);
          end
        end
      end
    end
  end

  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_start(output int t0);
    @(posedge clk);
    #1;
    i_ini_start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    i_ini_start = 1'b0;
  endtask

  // Model: 16-bit sum of channel words against the checksum word.
  task automatic push_expect(input int chk_c);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < CH; i++) s = s + mem[i];
    if (s == mem[CH]) begin
      for (int i = 0; i < CH; i++) wq.push_back('{chk_c + 1 + i, 3'(i), mem[i]});
      eq.push_back('{chk_c + 1 + CH, 1'b0});
    end else begin
      eq.push_back('{chk_c + 1, 1'b1});
    end
  endtask

  task automatic drain(input int c, input string name);
    at_cyc(c);
    vecs++;
    if (wq.size() != 0 || eq.size() != 0) begin
      errs++;
      $display("FAIL %s: pending writes %0d events %0d, want 0 0", name, wq.size(), eq.size());
      wq.delete();
      eq.delete();
    end
  endtask

  task automatic check_idle_outs(input string name);
    vecs++;
    if ({o_ini_done, o_ini_fail, o_busy, o_cfg_req, om_cfg_addr,
         o_ch_wr, om_ch_sel, om_ch_data} !== {4'b0000, BASE, 1'b0, 3'd0, 16'd0}) begin
      errs++;
      $display("FAIL %s: done %b fail %b busy %b req %b addr %h wr %b sel %0d data %h, want all 0 addr %h",
               name, o_ini_done, o_ini_fail, o_busy, o_cfg_req, om_cfg_addr,
               o_ch_wr, om_ch_sel, om_ch_data, BASE);
    end
  endtask

  task automatic load_seq();
    for (int i = 0; i < CH; i++) mem[i] = 16'(i + 1);
    mem[CH] = 16'h0024;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_pass();
    int t0;
    load_seq();
    i_cfg_ack = 1'b1;
    drive_start(t0);
    push_expect(t0 + 10);
    at_cyc(t0 + 1);
    vecs++;
    if (o_busy !== 1'b1 || o_cfg_req !== 1'b1 || om_cfg_addr !== BASE) begin
      errs++;
      $display("FAIL pass_req: busy %b req %b addr %h, want 1 1 %h", o_busy, o_cfg_req, om_cfg_addr, BASE);
    end
    at_cyc(t0 + 10);
    vecs++;
    if (o_cfg_req !== 1'b0) begin
      errs++;
      $display("FAIL pass_chk_req: req %b, want 0", o_cfg_req);
    end
    at_cyc(t0 + 19);
    vecs++;
    if (o_busy !== 1'b1) begin
      errs++;
      $display("FAIL pass_busy_end: busy %b, want 1", o_busy);
    end
    at_cyc(t0 + 20);
    vecs++;
    if (o_busy !== 1'b0) begin
      errs++;
      $display("FAIL pass_busy_after: busy %b, want 0", o_busy);
    end
    drain(t0 + 22, "pass_drain");
  endtask

  task automatic test_bad_csum();
    int t0;
    load_seq();
    mem[CH] = 16'h0025;
    i_cfg_ack = 1'b1;
    drive_start(t0);
    push_expect(t0 + 10);
    at_cyc(t0 + 12);
    vecs++;
    if (o_busy !== 1'b0) begin
      errs++;
      $display("FAIL badcs_busy: busy %b, want 0", o_busy);
    end
    drain(t0 + 25, "badcs_drain");
  endtask

  task automatic test_wrap();
    int t0;
    for (int i = 0; i < CH; i++) mem[i] = 16'hFFFF;
    mem[CH] = 16'hFFF8;
    i_cfg_ack = 1'b1;
    drive_start(t0);
    push_expect(t0 + 10);
    drain(t0 + 22, "wrap_drain");
  endtask

  task automatic test_timeout();
    int t0;
    load_seq();
    i_cfg_ack = 1'b1;
    drive_start(t0);
    repeat (4) @(posedge clk);
    #1;
    i_cfg_ack = 1'b0;
    eq.push_back('{t0 + 4 + TO, 1'b1});
    at_cyc(t0 + 5 + TO);
    vecs++;
    if (o_busy !== 1'b0 || o_cfg_req !== 1'b0) begin
      errs++;
      $display("FAIL to_after: busy %b req %b, want 0 0", o_busy, o_cfg_req);
    end
    drain(t0 + 10 + TO, "to_drain");
  endtask

  task automatic test_gaps();
    int t0;
    int last;
    int gap [CH+1];
    for (int i = 0; i <= CH; i++) gap[i] = 1;
    gap[0]  = TO - 1;
    gap[4]  = TO - 1;
    gap[CH] = TO - 1;
    for (int i = 0; i < CH; i++) mem[i] = 16'h1111 * 16'(i + 1);
    mem[CH] = 16'h9998;
    i_cfg_ack = 1'b0;
    drive_start(t0);
    last = t0;
    for (int i = 0; i <= CH; i++) last = last + gap[i];
    push_expect(last + 1);
    last = t0;
    for (int i = 0; i <= CH; i++) begin
      last = last + gap[i];
      i_cfg_ack = 1'b0;
      goto_cyc(last);
      i_cfg_ack = 1'b1;
      @(posedge clk);
      #1;
    end
    i_cfg_ack = 1'b0;
    drain(last + 14, "gaps_drain");
  endtask

  task automatic test_back_to_back();
    int t0;
    load_seq();
    i_cfg_ack = 1'b1;
    drive_start(t0);
    wq.push_back('{t0 + 11, 3'd0, 16'h0001});
    wq.push_back('{t0 + 12, 3'd1, 16'h0002});
    goto_cyc(t0 + 3);
    i_ini_start = 1'b1;
    @(posedge clk);
    #1;
    i_ini_start = 1'b0;
    goto_cyc(t0 + 13);
    rst = 1'b1;
    #1;
    check_idle_outs("rst_mid_wr");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drain(t0 + 30, "rst_drain");
    vecs++;
    if (o_busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy: busy %b, want 0", o_busy);
    end
    test_pass();
  endtask

  initial begin
    load_seq();
    test_reset();
    test_pass();
    test_bad_csum();
    test_wrap();
    test_timeout();
    test_gaps();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached at cyc %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
